// File: rtl/regfile_psr.sv
// Register file with two combinational read ports, one write port with bypass,
// a 5-bit flag register, and a sequential clear sweep started by reset or clear_req.
module regfile_psr #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             regwrite,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             flagwrite,
    input  logic [4:0]       flags_in,
    output logic [4:0]       psr,
    input  logic             clear_req,
    output logic             busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] regs [DEPTH];

    logic wa_ok, ra1_ok, ra2_ok, wq;

    assign wa_ok  = ({1'b0, wa}  < DEPTH_X);
    assign ra1_ok = ({1'b0, ra1} < DEPTH_X);
    assign ra2_ok = ({1'b0, ra2} < DEPTH_X);

    // clear_req only matters in IDLE, so !busy && !clear_req covers "no clear accepted"
    assign wq = reset_n && regwrite && !busy && !clear_req && wa_ok;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
            psr   <= 5'b00000;
        end else begin
            if (flagwrite)
                psr <= flags_in;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (idx == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage carries no reset; the sweep zeroes it one entry per cycle
    always_ff @(posedge clk) begin
        if (reset_n && busy)
            regs[idx] <= '0;
        else if (wq)
            regs[wa] <= wd;
    end

    always_comb begin
        rd1 = '0;
        if (!busy) begin
            if (wq && ra1 == wa)
                rd1 = wd;
            else if (ra1_ok)
                rd1 = regs[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (!busy) begin
            if (wq && ra2 == wa)
                rd2 = wd;
            else if (ra2_ok)
                rd2 = regs[ra2];
        end
    end

endmodule

// File: tb/tb_regfile_psr.sv
// Directed bench for regfile_psr: a default 16x16 instance and a 32x8 instance.
module tb_regfile_psr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, regwrite, flagwrite, clear_req;
    logic [3:0]  wa, ra1, ra2;
    logic [15:0] wd, rd1, rd2;
    logic [4:0]  flags_in, psr;
    logic        busy;

    logic        reset8_n, regwrite8;
    logic [2:0]  wa8, ra18, ra28;
    logic [31:0] wd8, rd18, rd28;
    logic [4:0]  psr8;
    logic        busy8;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_psr dut (
        .clk(clk), .reset_n(reset_n), .regwrite(regwrite), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .flagwrite(flagwrite),
        .flags_in(flags_in), .psr(psr), .clear_req(clear_req), .busy(busy)
    );

    regfile_psr #(.WIDTH(32), .DEPTH(8)) dut8 (
        .clk(clk), .reset_n(reset8_n), .regwrite(regwrite8), .wa(wa8), .wd(wd8),
        .ra1(ra18), .ra2(ra28), .rd1(rd18), .rd2(rd28), .flagwrite(1'b0),
        .flags_in(5'b00000), .psr(psr8), .clear_req(1'b0), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with busy high on the default instance, bounded at 100
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    int c1, c2;

    initial begin
        reset_n = 1'b0; regwrite = 1'b0; flagwrite = 1'b0; clear_req = 1'b0;
        wa = '0; wd = '0; ra1 = '0; ra2 = '0; flags_in = '0;
        reset8_n = 1'b0; regwrite8 = 1'b0; wa8 = '0; wd8 = '0; ra18 = '0; ra28 = '0;

        // Reset for two cycles, then count the sweep on both instances
        tick(); tick();
        check("rst_psr", 32'(psr), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_busy8", 32'(busy8), 32'h1);
        reset_n = 1'b1; reset8_n = 1'b1;
        c1 = 0; c2 = 0;
        for (int i = 0; i < 24; i++) begin
            if (busy)  c1++;
            if (busy8) c2++;
            tick();
        end
        check("rst_busy_len", 32'(c1), 32'd16);
        check("rst_busy_len8", 32'(c2), 32'd8);
        for (int a = 0; a < 16; a++) begin
            ra1 = 4'(a); ra2 = 4'(15 - a);
            #1;
            check($sformatf("rst_rd1_%0d", a), 32'(rd1), 32'h0);
            check($sformatf("rst_rd2_%0d", 15 - a), 32'(rd2), 32'h0);
        end

        // Write then read, and same-cycle bypass
        regwrite = 1'b1; wa = 4'd3; wd = 16'h000A;
        tick();
        regwrite = 1'b0; ra1 = 4'd3;
        #1;
        check("wr_rd1", 32'(rd1), 32'h000A);
        regwrite = 1'b1; wa = 4'd2; wd = 16'h000A; ra2 = 4'd2;
        #1;
        check("bypass_rd2", 32'(rd2), 32'h000A);
        wa = 4'd5; wd = 16'h7777;
        #1;
        check("nobypass_rd2", 32'(rd2), 32'h0);
        wa = 4'd2; wd = 16'h000A;
        tick();
        regwrite = 1'b0;
        #1;
        check("stored_rd2", 32'(rd2), 32'h000A);

        // Flag register load and hold
        flagwrite = 1'b1; flags_in = 5'b10001;
        tick();
        check("psr_load", 32'(psr), 32'h11);
        flagwrite = 1'b0; flags_in = 5'b01110;
        tick();
        check("psr_hold", 32'(psr), 32'h11);

        // clear_req beats a same-cycle write
        regwrite = 1'b1; wa = 4'd3; wd = 16'hFFFF;
        tick();
        regwrite = 1'b0; ra1 = 4'd3;
        #1;
        check("r3_ffff", 32'(rd1), 32'hFFFF);
        clear_req = 1'b1; regwrite = 1'b1; wa = 4'd3; wd = 16'h1234;
        #1;
        check("clr_no_bypass", 32'(rd1), 32'hFFFF);
        tick();
        clear_req = 1'b0; regwrite = 1'b0;
        check("clr_busy", 32'(busy), 32'h1);
        check("clr_rd_zero", 32'(rd1), 32'h0);
        count_busy(c1);
        check("clr_busy_len", 32'(c1), 32'd16);
        ra1 = 4'd3;
        #1;
        check("clr_r3_zero", 32'(rd1), 32'h0);

        // Writes ignored and flags still loadable during a sweep; clear_req pulse mid-sweep
        regwrite = 1'b1; wa = 4'd1; wd = 16'h5555;
        tick();
        regwrite = 1'b0; ra1 = 4'd1;
        #1;
        check("r1_5555", 32'(rd1), 32'h5555);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        c1 = 0;
        while (busy && c1 < 100) begin
            clear_req = (c1 == 4);
            flagwrite = (c1 == 6); flags_in = 5'b00110;
            regwrite = 1'b1; wa = 4'd0; wd = 16'h5A5A;
            c1++;
            tick();
        end
        clear_req = 1'b0; flagwrite = 1'b0; regwrite = 1'b0;
        check("pulse_busy_len", 32'(c1), 32'd16);
        check("psr_in_clear", 32'(psr), 32'h06);
        ra1 = 4'd0; ra2 = 4'd1;
        #1;
        check("busy_write_dropped", 32'(rd1), 32'h0);
        check("r1_cleared", 32'(rd2), 32'h0);

        // Reset at sweep index 7 restarts the full sweep and zeroes psr
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("mid_busy", 32'(busy), 32'h1);
        reset_n = 1'b0; flagwrite = 1'b1; flags_in = 5'b11111;
        tick();
        reset_n = 1'b1; flagwrite = 1'b0;
        check("mid_rst_psr", 32'(psr), 32'h0);
        count_busy(c1);
        check("mid_rst_busy_len", 32'(c1), 32'd16);

        // 32x8 instance: top address write and read-back
        regwrite8 = 1'b1; wa8 = 3'd7; wd8 = 32'hDEADBEEF;
        tick();
        regwrite8 = 1'b0; ra18 = 3'd7; ra28 = 3'd6;
        #1;
        check("w8_rd1", rd18, 32'hDEADBEEF);
        check("w8_rd2", rd28, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_psr.md
REGFILE_PSR -- requirements
Module: regfile_psr

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16, data word width in bits.
REQ-002 The block SHALL provide parameter DEPTH, default 16, number of registers (2..256).
REQ-003 The block SHALL provide parameter AW, default $clog2(DEPTH), address width in bits.
REQ-004 The block SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL provide port reset_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL provide port regwrite  input  1  write enable for port wa/wd.
REQ-007 The block SHALL provide port wa  input  AW  write address.
REQ-008 The block SHALL provide port wd  input  WIDTH  write data.
REQ-009 The block SHALL provide port ra1  input  AW  read address, port 1.
REQ-010 The block SHALL provide port ra2  input  AW  read address, port 2.
REQ-011 The block SHALL provide port rd1  output  WIDTH  read data, port 1.
REQ-012 The block SHALL provide port rd2  output  WIDTH  read data, port 2.
REQ-013 The block SHALL provide port flagwrite  input  1  PSR update enable.
REQ-014 The block SHALL provide port flags_in  input  5  ALU flags {C,L,F,Z,N}, bit4=C ... bit0=N.
REQ-015 The block SHALL provide port psr  output  5  registered flags, same bit order as flags_in.
REQ-016 The block SHALL provide port clear_req  input  1  one-cycle request to zero all registers.
REQ-017 The block SHALL provide port busy  output  1  high while a clear sweep is in progress.

Function
REQ-018 Reads SHALL be combinational: rdN = reg[raN], zero-cycle latency.
REQ-019 Writes SHALL occur at the rising edge when regwrite=1, busy=0, and no clear_req is accepted in that cycle.
REQ-020 Bypass: when a write qualifies (REQ-019) and raN==wa, rdN SHALL equal wd in that same cycle.
REQ-021 Addresses >= DEPTH (DEPTH not a power of 2) SHALL read 0; writes to them SHALL be ignored.
REQ-022 FSM states SHALL be IDLE and CLEAR; busy=1 exactly when state=CLEAR.
REQ-023 The FSM SHALL go IDLE->CLEAR on clear_req=1, loading sweep index 0; clear_req dominates regwrite in that cycle, and the write SHALL be dropped.
REQ-024 In CLEAR, each cycle SHALL write 0 to reg[index] and increment index; after writing index DEPTH-1 the FSM SHALL return to IDLE; busy SHALL be high for exactly DEPTH cycles.
REQ-025 clear_req during CLEAR SHALL be ignored; the sweep SHALL neither restart nor extend.
REQ-026 In CLEAR, regwrite SHALL be ignored and rd1/rd2 SHALL read 0.
REQ-027 psr SHALL load flags_in at the edge when flagwrite=1, independent of FSM state; otherwise psr SHALL hold.
REQ-028 The sweep index SHALL be AW bits wide and SHALL NOT wrap past DEPTH-1.

Reset
REQ-029 With reset_n=0 at an edge: psr SHALL become 5'b00000, the FSM SHALL enter CLEAR with index 0, and busy SHALL become 1.
REQ-030 Reset SHALL dominate flagwrite, regwrite and clear_req in the same cycle.
REQ-031 Reset asserted mid-sweep SHALL restart the sweep at index 0; after reset_n returns high, busy SHALL stay 1 for DEPTH cycles.
REQ-032 Register contents SHALL be guaranteed zero only once busy falls; no separate array reset is required.

Verification
REQ-033 reset_n=0 for 2 cycles, then 1 -> busy=1 for exactly 16 cycles, psr=0, and after busy falls rd1=rd2=0 for every address.
REQ-034 Write wa=3 wd=16'h000A, then ra1=3 on the next cycle -> rd1=16'h000A; same-cycle regwrite wa=2 wd=16'h000A with ra2=2 -> rd2=16'h000A before the edge.
REQ-035 flagwrite=1 flags_in=5'b10001 -> psr=5'b10001 after the edge; flagwrite=0 with flags_in=5'b01110 -> psr still 5'b10001.
REQ-036 r3=16'hFFFF, then clear_req=1 with regwrite wa=3 wd=16'h1234 in the same cycle -> write dropped, busy for 16 cycles, then reg[3] reads 0.
REQ-037 reset_n=0 while the sweep index is 7 -> index restarts at 0, busy=1 for 16 more cycles after release; clear_req pulsed mid-sweep -> no extension.
REQ-038 Instance WIDTH=32 DEPTH=8 -> busy lasts 8 cycles; write reg[7]=32'hDEADBEEF reads back on ra1=7; write to address 8 is unreachable (AW=3).
